// File: rtl/jump_control_stack_if.sv
// Bus between the fetch/decode datapath and the jump control stack.
// The datapath side drives the instruction context and reads back the
// redirect, flag-restore and stack status signals.
interface jump_control_stack_if #(
    parameter int ADDR_W = 8,
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic [19:0]       ins;
    logic [ADDR_W-1:0] current_address;
    logic [FLAG_W-1:0] flag_ex;
    logic              interrupt;

    logic              pc_mux_sel;
    logic [ADDR_W-1:0] jmp_loc;
    logic              flag_restore_en;
    logic [FLAG_W-1:0] flag_restore;
    logic              in_isr;
    logic [SP_W-1:0]   sp;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output ins, current_address, flag_ex, interrupt,
        input  pc_mux_sel, jmp_loc, flag_restore_en, flag_restore,
        input  in_isr, sp, stack_ovf, stack_unf
    );

    modport slave (
        input  ins, current_address, flag_ex, interrupt,
        output pc_mux_sel, jmp_loc, flag_restore_en, flag_restore,
        output in_isr, sp, stack_ovf, stack_unf
    );
endinterface

// File: rtl/jump_control_stack.sv
// Jump/call/return control with a small hardware return stack.
// Redirects are combinational from the current instruction; CALL and
// accepted interrupts push {irq, flags, address} frames, RET pops them.
// An accepted interrupt spends one extra cycle forcing the PC to VECTOR.
module jump_control_stack #(
    parameter int              ADDR_W = 8,
    parameter int              FLAG_W = 4,
    parameter int              DEPTH  = 4,
    parameter logic [ADDR_W-1:0] VECTOR = ADDR_W'(8'hF0)
) (
    input  logic clk,
    input  logic reset,
    jump_control_stack_if.slave bus
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_JC   = 5'b11100;
    localparam logic [4:0] OP_JNC  = 5'b11101;
    localparam logic [4:0] OP_JZ   = 5'b11110;
    localparam logic [4:0] OP_JNZ  = 5'b11111;
    localparam logic [4:0] OP_RET  = 5'b10000;

    // ST_VECTOR is the single cycle after interrupt acceptance
    typedef enum logic {
        ST_RUN,
        ST_VECTOR
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [SP_W-1:0]   r_sp;
    logic              r_inIsr;
    logic              r_stackOvf;
    logic              r_stackUnf;
    logic [ADDR_W-1:0] r_stackAddr [DEPTH];
    logic [FLAG_W-1:0] r_stackFlag [DEPTH];
    logic              r_stackIrq  [DEPTH];

    logic [4:0]        w_opcode;
    logic [ADDR_W-1:0] w_target;
    logic [SP_W-1:0]   w_spMinusOne;
    logic [IDX_W-1:0]  w_topIdx;
    logic [IDX_W-1:0]  w_pushIdx;
    logic              w_spFull;
    logic              w_spEmpty;
    logic              w_isCall;
    logic              w_isRet;
    logic              w_jumpTaken;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_setOvf;
    logic              w_setUnf;
    logic              w_pcMuxSel;
    logic [ADDR_W-1:0] w_jmpLoc;
    logic              w_flagRestoreEn;
    logic [FLAG_W-1:0] w_flagRestore;
    logic              w_unusedInsBits;

    assign w_opcode        = bus.ins[19:15];
    assign w_target        = bus.ins[ADDR_W-1:0];
    assign w_unusedInsBits = ^bus.ins[14:ADDR_W];
    assign w_spMinusOne    = r_sp - SP_W'(1);
    assign w_topIdx        = w_spMinusOne[IDX_W-1:0];
    assign w_pushIdx       = r_sp[IDX_W-1:0];
    assign w_spFull        = (r_sp == SP_FULL);
    assign w_spEmpty       = (r_sp == '0);

    // Classify the instruction and resolve conditional jumps on live flags
    always_comb begin
        w_isCall    = 1'b0;
        w_isRet     = 1'b0;
        w_jumpTaken = 1'b0;
        case (w_opcode)
            OP_JMP:  w_jumpTaken = 1'b1;
            OP_CALL: w_isCall    = 1'b1;
            OP_JC:   w_jumpTaken = bus.flag_ex[0];
            OP_JNC:  w_jumpTaken = ~bus.flag_ex[0];
            OP_JZ:   w_jumpTaken = bus.flag_ex[1];
            OP_JNZ:  w_jumpTaken = ~bus.flag_ex[1];
            OP_RET:  w_isRet     = 1'b1;
            default: ;
        endcase
    end

    // Redirect outputs, stack operation requests and next FSM state
    always_comb begin
        w_pcMuxSel      = 1'b0;
        w_jmpLoc        = w_target;
        w_flagRestoreEn = 1'b0;
        w_flagRestore   = '0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_accept        = 1'b0;
        w_setOvf        = 1'b0;
        w_setUnf        = 1'b0;
        w_nextState     = r_state;

        if (r_state == ST_VECTOR) begin
            w_pcMuxSel  = 1'b1;
            w_jmpLoc    = VECTOR;
            w_nextState = ST_RUN;
        end else if (w_isCall) begin
            w_pcMuxSel = 1'b1;
            if (w_spFull) begin
                w_setOvf = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (w_isRet) begin
            if (w_spEmpty) begin
                w_setUnf = 1'b1;
            end else begin
                w_pcMuxSel      = 1'b1;
                w_jmpLoc        = r_stackAddr[w_topIdx];
                w_flagRestoreEn = 1'b1;
                w_flagRestore   = r_stackFlag[w_topIdx];
                w_pop           = 1'b1;
            end
        end else if (w_jumpTaken) begin
            w_pcMuxSel = 1'b1;
        end else if (bus.interrupt && !r_inIsr && !w_spFull) begin
            w_accept    = 1'b1;
            w_push      = 1'b1;
            w_nextState = ST_VECTOR;
        end

        if (reset) begin
            w_pcMuxSel      = 1'b0;
            w_jmpLoc        = '0;
            w_flagRestoreEn = 1'b0;
            w_flagRestore   = '0;
        end
    end

    assign bus.pc_mux_sel      = w_pcMuxSel;
    assign bus.jmp_loc         = w_jmpLoc;
    assign bus.flag_restore_en = w_flagRestoreEn;
    assign bus.flag_restore    = w_flagRestore;
    assign bus.in_isr          = r_inIsr;
    assign bus.sp              = r_sp;
    assign bus.stack_ovf       = r_stackOvf;
    assign bus.stack_unf       = r_stackUnf;

    // FSM state register; reset drops any pending vector jump at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Return stack, occupancy, ISR mask and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp       <= '0;
            r_inIsr    <= 1'b0;
            r_stackOvf <= 1'b0;
            r_stackUnf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stackAddr[i] <= '0;
                r_stackFlag[i] <= '0;
                r_stackIrq[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_stackAddr[w_pushIdx] <= bus.current_address;
                r_stackFlag[w_pushIdx] <= bus.flag_ex;
                r_stackIrq[w_pushIdx]  <= w_accept;
                r_sp                   <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= w_spMinusOne;
            end
            if (w_accept) begin
                r_inIsr <= 1'b1;
            end else if (w_pop && r_stackIrq[w_topIdx]) begin
                r_inIsr <= 1'b0;
            end
            if (w_setOvf) begin
                r_stackOvf <= 1'b1;
            end
            if (w_setUnf) begin
                r_stackUnf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jump_control_stack.sv
// Directed, table-driven bench for jump_control_stack (DEPTH=4, 8-bit
// addresses, VECTOR=8'hF0). Inputs change on the falling edge and outputs
// are sampled 1ns later, so each record describes one clock cycle.
module tb_jump_control_stack;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_JC   = 5'b11100;
    localparam logic [4:0] OP_JNC  = 5'b11101;
    localparam logic [4:0] OP_JZ   = 5'b11110;
    localparam logic [4:0] OP_JNZ  = 5'b11111;
    localparam logic [4:0] OP_RET  = 5'b10000;

    typedef struct {
        logic [19:0] ins;
        logic [7:0]  addr;
        logic [3:0]  flags;
        logic        irq;
        logic        expPc;
        logic [7:0]  expJmp;
        logic        expFre;
        logic [3:0]  expFr;
        logic [2:0]  expSp;
        logic        expIsr;
        logic        expOvf;
        logic        expUnf;
    } vec_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    vec_t table_q[$];

    jump_control_stack_if #(.ADDR_W(8), .FLAG_W(4), .DEPTH(4)) bus ();

    jump_control_stack #(
        .ADDR_W(8),
        .FLAG_W(4),
        .DEPTH (4),
        .VECTOR(8'hF0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(logic [4:0] op, logic [7:0] tgt, logic [7:0] addr,
                                   logic [3:0] flags, logic irq, logic pc, logic [7:0] jmp,
                                   logic fre, logic [3:0] fr, logic [2:0] sp, logic isr,
                                   logic ovf, logic unf);
        vec_t v;
        v.ins    = {op, 7'b0, tgt};
        v.addr   = addr;
        v.flags  = flags;
        v.irq    = irq;
        v.expPc  = pc;
        v.expJmp = jmp;
        v.expFre = fre;
        v.expFr  = fr;
        v.expSp  = sp;
        v.expIsr = isr;
        v.expOvf = ovf;
        v.expUnf = unf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [19:0] ins, input logic [7:0] addr,
                                 input logic [3:0] flags, input logic irq);
        bus.ins             = ins;
        bus.current_address = addr;
        bus.flag_ex         = flags;
        bus.interrupt       = irq;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v.ins, v.addr, v.flags, v.irq);
        #1;
        checkOutput({tag, " pc_mux_sel"}, 32'(bus.pc_mux_sel), 32'(v.expPc));
        checkOutput({tag, " jmp_loc"}, 32'(bus.jmp_loc), 32'(v.expJmp));
        checkOutput({tag, " flag_restore_en"}, 32'(bus.flag_restore_en), 32'(v.expFre));
        if (v.expFre) begin
            checkOutput({tag, " flag_restore"}, 32'(bus.flag_restore), 32'(v.expFr));
        end
        checkOutput({tag, " sp"}, 32'(bus.sp), 32'(v.expSp));
        checkOutput({tag, " in_isr"}, 32'(bus.in_isr), 32'(v.expIsr));
        checkOutput({tag, " stack_ovf"}, 32'(bus.stack_ovf), 32'(v.expOvf));
        checkOutput({tag, " stack_unf"}, 32'(bus.stack_unf), 32'(v.expUnf));
    endtask

    task automatic doReset();
        @(negedge clk);
        applyStimulus({OP_NOP, 15'h0}, 8'h00, 4'h0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Main sequence: reset values, vector table, then multi-cycle corner cases
    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        applyStimulus({OP_JMP, 7'b0, 8'h55}, 8'h10, 4'hF, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset pc_mux_sel", 32'(bus.pc_mux_sel), 32'd0);
        checkOutput("reset jmp_loc", 32'(bus.jmp_loc), 32'd0);
        checkOutput("reset flag_restore_en", 32'(bus.flag_restore_en), 32'd0);
        checkOutput("reset sp", 32'(bus.sp), 32'd0);
        checkOutput("reset in_isr", 32'(bus.in_isr), 32'd0);
        checkOutput("reset stack_ovf", 32'(bus.stack_ovf), 32'd0);
        checkOutput("reset stack_unf", 32'(bus.stack_unf), 32'd0);
        applyStimulus({OP_NOP, 15'h0}, 8'h00, 4'h0, 1'b0);
        reset = 1'b0;

        //                  op       tgt    addr   flags  irq  pc  jmp    fre fr     sp isr ovf unf
        // conditional and unconditional jumps
        table_q.push_back(mkVec(OP_JZ,   8'h40, 8'h10, 4'b0010, 0, 1, 8'h40, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JZ,   8'h40, 8'h10, 4'b0000, 0, 0, 8'h40, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JC,   8'h33, 8'h11, 4'b0001, 0, 1, 8'h33, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JC,   8'h33, 8'h11, 4'b0010, 0, 0, 8'h33, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JNC,  8'h34, 8'h11, 4'b0010, 0, 1, 8'h34, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JNC,  8'h34, 8'h11, 4'b0001, 0, 0, 8'h34, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JNZ,  8'h35, 8'h11, 4'b0001, 0, 1, 8'h35, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JNZ,  8'h35, 8'h11, 4'b0010, 0, 0, 8'h35, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_JMP,  8'h55, 8'h11, 4'b0000, 0, 1, 8'h55, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_NOP,  8'h77, 8'h11, 4'b0011, 0, 0, 8'h77, 0, 4'h0, 0, 0, 0, 0));
        // CALL then RET restores address and flags
        table_q.push_back(mkVec(OP_CALL, 8'h80, 8'h12, 4'b0011, 0, 1, 8'h80, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_RET,  8'h00, 8'h80, 4'b0000, 0, 1, 8'h12, 1, 4'b0011, 1, 0, 0, 0));
        table_q.push_back(mkVec(OP_NOP,  8'h00, 8'h13, 4'b0000, 0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0));
        // interrupt accept, vector cycle, masking, return
        table_q.push_back(mkVec(OP_NOP,  8'h05, 8'h20, 4'b0100, 1, 0, 8'h05, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_NOP,  8'h06, 8'h21, 4'b0000, 1, 1, 8'hF0, 0, 4'h0, 1, 1, 0, 0));
        table_q.push_back(mkVec(OP_NOP,  8'h07, 8'hF0, 4'b0000, 1, 0, 8'h07, 0, 4'h0, 1, 1, 0, 0));
        table_q.push_back(mkVec(OP_RET,  8'h00, 8'hF1, 4'b0000, 1, 1, 8'h20, 1, 4'b0100, 1, 1, 0, 0));
        table_q.push_back(mkVec(OP_NOP,  8'h08, 8'h20, 4'b0000, 0, 0, 8'h08, 0, 4'h0, 0, 0, 0, 0));
        // fill the stack, overflow, blocked interrupt, drain, underflow
        table_q.push_back(mkVec(OP_CALL, 8'hA0, 8'h30, 4'b0001, 0, 1, 8'hA0, 0, 4'h0, 0, 0, 0, 0));
        table_q.push_back(mkVec(OP_CALL, 8'hA1, 8'h31, 4'b0010, 0, 1, 8'hA1, 0, 4'h0, 1, 0, 0, 0));
        table_q.push_back(mkVec(OP_CALL, 8'hA2, 8'h32, 4'b0011, 0, 1, 8'hA2, 0, 4'h0, 2, 0, 0, 0));
        table_q.push_back(mkVec(OP_CALL, 8'hA3, 8'h33, 4'b0100, 0, 1, 8'hA3, 0, 4'h0, 3, 0, 0, 0));
        table_q.push_back(mkVec(OP_CALL, 8'hA4, 8'h34, 4'b0101, 0, 1, 8'hA4, 0, 4'h0, 4, 0, 0, 0));
        table_q.push_back(mkVec(OP_NOP,  8'h0C, 8'h35, 4'b0000, 1, 0, 8'h0C, 0, 4'h0, 4, 0, 1, 0));
        table_q.push_back(mkVec(OP_RET,  8'h00, 8'h50, 4'b0000, 0, 1, 8'h33, 1, 4'b0100, 4, 0, 1, 0));
        table_q.push_back(mkVec(OP_RET,  8'h00, 8'h34, 4'b0000, 0, 1, 8'h32, 1, 4'b0011, 3, 0, 1, 0));
        table_q.push_back(mkVec(OP_RET,  8'h00, 8'h33, 4'b0000, 0, 1, 8'h31, 1, 4'b0010, 2, 0, 1, 0));
        table_q.push_back(mkVec(OP_RET,  8'h00, 8'h32, 4'b0000, 0, 1, 8'h30, 1, 4'b0001, 1, 0, 1, 0));
        table_q.push_back(mkVec(OP_RET,  8'h00, 8'h31, 4'b0000, 0, 0, 8'h00, 0, 4'h0, 0, 0, 1, 0));
        table_q.push_back(mkVec(OP_NOP,  8'h09, 8'h32, 4'b0000, 0, 0, 8'h09, 0, 4'h0, 0, 0, 1, 1));

        for (int i = 0; i < table_q.size(); i++) begin
            runVector(table_q[i], $sformatf("vec%0d", i));
        end

        // Interrupt held across a CALL is deferred; CALL frame sits below it
        doReset();
        runVector(mkVec(OP_CALL, 8'h80, 8'h40, 4'b0001, 1, 1, 8'h80, 0, 4'h0, 0, 0, 0, 0), "irqcall_a");
        runVector(mkVec(OP_NOP,  8'h01, 8'h80, 4'b0010, 1, 0, 8'h01, 0, 4'h0, 1, 0, 0, 0), "irqcall_b");
        runVector(mkVec(OP_CALL, 8'h02, 8'h81, 4'b0000, 1, 1, 8'hF0, 0, 4'h0, 2, 1, 0, 0), "irqcall_c");
        runVector(mkVec(OP_RET,  8'h00, 8'hF0, 4'b0000, 0, 1, 8'h80, 1, 4'b0010, 2, 1, 0, 0), "irqcall_d");
        runVector(mkVec(OP_RET,  8'h00, 8'h80, 4'b0000, 0, 1, 8'h40, 1, 4'b0001, 1, 0, 0, 0), "irqcall_e");
        runVector(mkVec(OP_NOP,  8'h03, 8'h40, 4'b0000, 0, 0, 8'h03, 0, 4'h0, 0, 0, 0, 0), "irqcall_f");

        // Reset pulsed during the vector cycle drops the frame immediately
        doReset();
        runVector(mkVec(OP_NOP, 8'h04, 8'h60, 4'b0000, 1, 0, 8'h04, 0, 4'h0, 0, 0, 0, 0), "rstvec_accept");
        @(negedge clk);
        applyStimulus({OP_NOP, 7'b0, 8'h66}, 8'h61, 4'h0, 1'b0);
        #1;
        checkOutput("rstvec pre pc_mux_sel", 32'(bus.pc_mux_sel), 32'd1);
        checkOutput("rstvec pre jmp_loc", 32'(bus.jmp_loc), 32'hF0);
        reset = 1'b1;
        #1;
        checkOutput("rstvec pc_mux_sel", 32'(bus.pc_mux_sel), 32'd0);
        checkOutput("rstvec jmp_loc", 32'(bus.jmp_loc), 32'd0);
        checkOutput("rstvec sp", 32'(bus.sp), 32'd0);
        checkOutput("rstvec in_isr", 32'(bus.in_isr), 32'd0);
        @(negedge clk);
        applyStimulus({OP_NOP, 7'b0, 8'h0A}, 8'h62, 4'h0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rstvec post pc_mux_sel", 32'(bus.pc_mux_sel), 32'd0);
        checkOutput("rstvec post jmp_loc", 32'(bus.jmp_loc), 32'h0A);
        runVector(mkVec(OP_NOP, 8'h0B, 8'h63, 4'b0000, 0, 0, 8'h0B, 0, 4'h0, 0, 0, 0, 0), "rstvec_nop");
        runVector(mkVec(OP_JMP, 8'h44, 8'h64, 4'b0000, 0, 1, 8'h44, 0, 4'h0, 0, 0, 0, 0), "rstvec_jmp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
